// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Holds the last result steady on bcd/ovf between conversions.
module bin2bcd_seq #(
  parameter int unsigned DIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [DIN_W-1:0]      din,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (DIN_W > 1) ? $clog2(DIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIN_W - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DIN_W-1:0]   shreg;
  logic [BCD_W-1:0]   scratch;
  logic               sticky;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scratch_nxt;
  logic               carry;

  // Add-3 correction on every nibble in parallel, evaluated on pre-edge scratch.
  always_comb begin
    adj = scratch;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (scratch[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
      end
    end
  end

  // The bit shifted out of the top nibble is a carry worth 10**DIGITS.
  assign scratch_nxt = {adj[BCD_W-2:0], shreg[DIN_W-1]};
  assign carry       = adj[BCD_W-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      scratch <= '0;
      sticky  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg   <= din;
            scratch <= '0;
            sticky  <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          scratch <= scratch_nxt;
          shreg   <= shreg << 1;
          sticky  <= sticky | carry;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            bcd   <= scratch_nxt;
            ovf   <= sticky | carry;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
